// File: rtl/stream_mux_rr.sv
// N-channel, W-bit stream multiplexer with round-robin arbitration and a one-word registered output stage.
// Optional manual channel select is compiled in with `define STREAM_MUX_FORCE_SEL_EN.
module stream_mux_rr #(
    parameter int N = 4,
    parameter int W = 8,
    localparam int CW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N*W-1:0]  in_data,
    input  logic [N-1:0]    in_valid,
    output logic [N-1:0]    in_ready,
    output logic [W-1:0]    out_data,
    output logic [CW-1:0]   out_chan,
    output logic            out_valid,
    input  logic            out_ready,
    input  logic            force_en,
    input  logic [CW-1:0]   sel,
    output logic [CW-1:0]   dbg_ptr
);

    // Handshake: a word moves on any port in the cycle where valid and ready are
    // both high at the rising edge; ready never depends on the data lines.

    logic [CW-1:0] ptr;
    logic          load_en;
    logic          force_active;
    logic          grant_any;
    logic [CW-1:0] grant_idx;
    logic [CW-1:0] cand_idx;
    logic [N-1:0]  grant_onehot;
    logic [W-1:0]  grant_data;
    logic          transfer;

`ifdef STREAM_MUX_FORCE_SEL_EN
    assign force_active = force_en;
`else
    logic force_unused;
    assign force_unused = force_en;
    assign force_active = 1'b0;
`endif

    // The output register can take a word when empty or being drained this cycle.
    assign load_en = !out_valid || out_ready;

    // Grant selection: forced channel when manual select is active, otherwise
    // the first valid channel after ptr, wrapping modulo N.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand_idx  = '0;
        if (force_active) begin
            for (int i = 0; i < N; i++) begin
                if (CW'(i) == sel && in_valid[i]) begin
                    grant_any = 1'b1;
                    grant_idx = CW'(i);
                end
            end
        end else begin
            for (int k = 1; k <= N; k++) begin
                cand_idx = CW'((int'(ptr) + k) % N);
                if (!grant_any && in_valid[cand_idx]) begin
                    grant_any = 1'b1;
                    grant_idx = cand_idx;
                end
            end
        end
    end

    always_comb begin
        grant_onehot = '0;
        grant_data   = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_any && grant_idx == CW'(i)) begin
                grant_onehot[i] = 1'b1;
                grant_data      = in_data[i*W +: W];
            end
        end
    end

    assign in_ready = grant_onehot & {N{load_en && !rst}};
    assign transfer = grant_any && load_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
            ptr       <= CW'(N - 1);
        end else if (load_en) begin
            if (transfer) begin
                out_data  <= grant_data;
                out_chan  <= grant_idx;
                out_valid <= 1'b1;
                ptr       <= grant_idx;
            end else begin
                // Drain (or stay empty); data and channel keep their last value.
                out_valid <= 1'b0;
            end
        end
    end

    assign dbg_ptr = ptr;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr: a vector table for a 4-channel instance and
// hand-written sequences for a 3-channel instance and the manual-select mode.
module tb_stream_mux_rr;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [7:0]  out_data;
    logic [1:0]  out_chan;
    logic        out_valid;
    logic        out_ready;
    logic        force_en;
    logic [1:0]  sel;
    logic [1:0]  dbg_ptr;

    logic [23:0] in_data3;
    logic [2:0]  in_valid3;
    logic [2:0]  in_ready3;
    logic [7:0]  out_data3;
    logic [1:0]  out_chan3;
    logic        out_valid3;
    logic        out_ready3;
    logic        force_en3;
    logic [1:0]  sel3;
    logic [1:0]  dbg_ptr3;

    stream_mux_rr #(.N(4), .W(8)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .out_data(out_data), .out_chan(out_chan),
        .out_valid(out_valid), .out_ready(out_ready), .force_en(force_en),
        .sel(sel), .dbg_ptr(dbg_ptr)
    );

    stream_mux_rr #(.N(3), .W(8)) dut3 (
        .clk(clk), .rst(rst), .in_data(in_data3), .in_valid(in_valid3),
        .in_ready(in_ready3), .out_data(out_data3), .out_chan(out_chan3),
        .out_valid(out_valid3), .out_ready(out_ready3), .force_en(force_en3),
        .sel(sel3), .dbg_ptr(dbg_ptr3)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One row = inputs held for one cycle plus the values expected just before
    // the following rising edge.
    typedef struct {
        logic        rst;
        logic [3:0]  in_valid;
        logic [31:0] in_data;
        logic        out_ready;
        logic [3:0]  exp_ready;
        logic        exp_valid;
        logic [7:0]  exp_data;
        logic [1:0]  exp_chan;
        logic [1:0]  exp_ptr;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs[NV];

    function automatic vec_t mk(input logic r, input logic [3:0] v, input logic [31:0] d,
                                input logic ordy, input logic [3:0] erdy, input logic ev,
                                input logic [7:0] ed, input logic [1:0] ec, input logic [1:0] ep);
        vec_t t;
        t.rst = r; t.in_valid = v; t.in_data = d; t.out_ready = ordy;
        t.exp_ready = erdy; t.exp_valid = ev; t.exp_data = ed; t.exp_chan = ec; t.exp_ptr = ep;
        return t;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] exp_chan_q[$];
        logic [1:0] ec;
        localparam logic [31:0] D4 = 32'h13121110;

        //                r   valid    data          ordy rdy     ov    data   ch  ptr
        vecs[0]  = mk(1'b0, 4'b0000, D4,           1'b1, 4'b0000, 1'b0, 8'h00, 2'd0, 2'd3);
        vecs[1]  = mk(1'b0, 4'b0100, 32'h13A51110, 1'b1, 4'b0100, 1'b0, 8'h00, 2'd0, 2'd3);
        vecs[2]  = mk(1'b0, 4'b0000, D4,           1'b1, 4'b0000, 1'b1, 8'hA5, 2'd2, 2'd2);
        vecs[3]  = mk(1'b1, 4'b0000, D4,           1'b1, 4'b0000, 1'b0, 8'hA5, 2'd2, 2'd2);
        vecs[4]  = mk(1'b0, 4'b1111, D4,           1'b1, 4'b0001, 1'b0, 8'h00, 2'd0, 2'd3);
        vecs[5]  = mk(1'b0, 4'b1111, D4,           1'b1, 4'b0010, 1'b1, 8'h10, 2'd0, 2'd0);
        vecs[6]  = mk(1'b0, 4'b1111, D4,           1'b1, 4'b0100, 1'b1, 8'h11, 2'd1, 2'd1);
        vecs[7]  = mk(1'b0, 4'b1111, D4,           1'b1, 4'b1000, 1'b1, 8'h12, 2'd2, 2'd2);
        vecs[8]  = mk(1'b0, 4'b1111, D4,           1'b1, 4'b0001, 1'b1, 8'h13, 2'd3, 2'd3);
        vecs[9]  = mk(1'b0, 4'b1111, D4,           1'b1, 4'b0010, 1'b1, 8'h10, 2'd0, 2'd0);
        vecs[10] = mk(1'b0, 4'b1111, D4,           1'b0, 4'b0000, 1'b1, 8'h11, 2'd1, 2'd1);
        vecs[11] = mk(1'b0, 4'b1111, D4,           1'b0, 4'b0000, 1'b1, 8'h11, 2'd1, 2'd1);
        vecs[12] = mk(1'b0, 4'b1111, D4,           1'b0, 4'b0000, 1'b1, 8'h11, 2'd1, 2'd1);
        vecs[13] = mk(1'b0, 4'b1111, D4,           1'b1, 4'b0100, 1'b1, 8'h11, 2'd1, 2'd1);
        vecs[14] = mk(1'b0, 4'b0000, D4,           1'b0, 4'b0000, 1'b1, 8'h12, 2'd2, 2'd2);
        vecs[15] = mk(1'b1, 4'b0000, D4,           1'b0, 4'b0000, 1'b1, 8'h12, 2'd2, 2'd2);
        vecs[16] = mk(1'b0, 4'b1010, D4,           1'b0, 4'b0010, 1'b0, 8'h00, 2'd0, 2'd3);
        vecs[17] = mk(1'b0, 4'b0000, D4,           1'b1, 4'b0000, 1'b1, 8'h11, 2'd1, 2'd1);
        vecs[18] = mk(1'b0, 4'b0000, D4,           1'b1, 4'b0000, 1'b0, 8'h11, 2'd1, 2'd1);

        // Clock/reset
        rst = 1'b1; in_data = D4; in_valid = '0; out_ready = 1'b1; force_en = 1'b0; sel = '0;
        in_data3 = 24'h323130; in_valid3 = '0; out_ready3 = 1'b1; force_en3 = 1'b0; sel3 = '0;
        next_cycle();
        next_cycle();

        // Table: 4-channel instance
        for (int i = 0; i < NV; i++) begin
            rst = vecs[i].rst; in_valid = vecs[i].in_valid;
            in_data = vecs[i].in_data; out_ready = vecs[i].out_ready;
            #1;
            check($sformatf("v%0d in_ready", i), 64'(in_ready), 64'(vecs[i].exp_ready));
            check($sformatf("v%0d out_valid", i), 64'(out_valid), 64'(vecs[i].exp_valid));
            check($sformatf("v%0d out_data", i), 64'(out_data), 64'(vecs[i].exp_data));
            check($sformatf("v%0d out_chan", i), 64'(out_chan), 64'(vecs[i].exp_chan));
            check($sformatf("v%0d ptr", i), 64'(dbg_ptr), 64'(vecs[i].exp_ptr));
            next_cycle();
        end
        in_valid = '0;

        // Manual select on the 4-channel instance: all valid, sel=3.
        rst = 1'b1;
        next_cycle();
        rst = 1'b0; in_valid = 4'b1111; out_ready = 1'b1; force_en = 1'b1; sel = 2'd3;
`ifdef STREAM_MUX_FORCE_SEL_EN
        exp_chan_q = '{2'd3, 2'd3, 2'd3, 2'd3};
`else
        exp_chan_q = '{2'd0, 2'd1, 2'd2, 2'd3};
`endif
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            ec = exp_chan_q.pop_front();
            check($sformatf("force4 c%0d out_chan", k), 64'(out_chan), 64'(ec));
            check($sformatf("force4 c%0d out_valid", k), 64'(out_valid), 64'(1'b1));
            check($sformatf("force4 c%0d out_data", k), 64'(out_data), 64'(8'h10 + 8'(ec)));
        end
        in_valid = '0; force_en = 1'b0; sel = '0;

        // 3-channel instance: ch0 and ch2 valid from reset (ptr=2) -> 0,2,0,2.
        rst = 1'b1;
        next_cycle();
        rst = 1'b0; in_valid3 = 3'b101; out_ready3 = 1'b1;
        #1;
        check("n3 first in_ready", 64'(in_ready3), 64'(3'b001));
        exp_chan_q = '{2'd0, 2'd2, 2'd0, 2'd2};
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            ec = exp_chan_q.pop_front();
            check($sformatf("n3 c%0d out_chan", k), 64'(out_chan3), 64'(ec));
            check($sformatf("n3 c%0d out_data", k), 64'(out_data3), 64'(8'h30 + 8'(ec)));
        end

        // Out-of-range manual select (sel=3 with N=3).
        in_valid3 = 3'b111; force_en3 = 1'b1; sel3 = 2'd3;
        #1;
`ifdef STREAM_MUX_FORCE_SEL_EN
        check("n3 force in_ready", 64'(in_ready3), 64'(3'b000));
        next_cycle();
        check("n3 force out_valid", 64'(out_valid3), 64'(1'b0));
`else
        check("n3 force in_ready", 64'(in_ready3), 64'(3'b001));
        next_cycle();
        check("n3 force out_valid", 64'(out_valid3), 64'(1'b1));
        check("n3 force out_chan", 64'(out_chan3), 64'(2'd0));
`endif
        in_valid3 = '0; force_en3 = 1'b0;
        next_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
